// File: rtl/pipelined_adder_pkg.sv
// Shared ALU definitions: default operand geometry and the add/subtract mode encodings.
package pipelined_adder_pkg;
    localparam int   DEFAULT_WIDTH  = 32;
    localparam int   DEFAULT_STAGES = 4;
    localparam logic MODE_ADD       = 1'b0;
    localparam logic MODE_SUB       = 1'b1;
endpackage

// File: rtl/adder_slice.sv
// Combinational S-bit ripple-carry slice; each full adder is two half adders plus an OR.
module adder_slice #(
    parameter int S = 8
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [S:0]   c;
    logic [S-1:0] hs;
    logic [S-1:0] hc1;
    logic [S-1:0] hc2;

    assign c[0] = cin;

    for (genvar i = 0; i < S; i++) begin : g_fa
        half_adder u_ha0 (.a(a[i]),  .b(b[i]), .s(hs[i]),  .c(hc1[i]));
        half_adder u_ha1 (.a(hs[i]), .b(c[i]), .s(sum[i]), .c(hc2[i]));
        assign c[i+1] = hc1[i] | hc2[i];
    end

    assign cout  = c[S];
    assign c_msb = c[S-1];
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell, the building block of every slice's ripple chain.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit resolving one S-bit slice per register stage, with the
// carry rippling stage to stage under a valid/ready handshake.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int S = WIDTH / STAGES;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // The A word rotates right by one slice per stage: finished sum bits enter at the top
    // while unsummed A bits drain from the bottom, so the last stage holds an aligned SUM.
    // B only needs its unsummed bits, so its skew register narrows by S every stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int XW = WIDTH - k * S;

        logic [WIDTH-1:0] xa;
        logic [XW-1:0]    xb;
        logic             xc;
        logic             xv;
        logic [S-1:0]     ssum;
        logic             scout;
        logic             smsb;
        logic [WIDTH-1:0] na;

        if (k == 0) begin : g_head
            assign xa = a;
            assign xb = (sub == MODE_SUB) ? ~b : b;
            assign xc = (sub == MODE_SUB) ? 1'b1 : cin;
            assign xv = in_valid;
        end else begin : g_tail
            assign xa = g_stage[k-1].g_mid.ra;
            assign xb = g_stage[k-1].g_mid.rb;
            assign xc = g_stage[k-1].g_mid.rc;
            assign xv = g_stage[k-1].g_mid.rv;
        end

        adder_slice #(.S(S)) u_slice (
            .a     (xa[S-1:0]),
            .b     (xb[S-1:0]),
            .cin   (xc),
            .sum   (ssum),
            .cout  (scout),
            .c_msb (smsb)
        );

        assign na = (xa >> S) | (WIDTH'(ssum) << (WIDTH - S));

        if (k < STAGES - 1) begin : g_mid
            localparam int RW = XW - S;

            logic [WIDTH-1:0] ra;
            logic [RW-1:0]    rb;
            logic             rc;
            logic             rv;
            logic             unused_msb;

            // Only the top slice's carry-into-MSB matters for overflow.
            assign unused_msb = smsb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rv <= 1'b0;
                end else if (en) begin
                    rv <= xv;
                    ra <= na;
                    rb <= xb[XW-1:S];
                    rc <= scout;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    carry     <= 1'b0;
                    ovf       <= 1'b0;
                end else if (en) begin
                    out_valid <= xv;
                    sum       <= na;
                    carry     <= scout;
                    ovf       <= scout ^ smsb;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four WIDTH=8 instances (STAGES=1,2,4,8) share stimulus, each
// checked every cycle against a queue model; directed tests pin the STAGES=2 instance.
module tb_pipelined_adder;
    localparam int W    = 8;
    localparam int NCFG = 4;
    localparam int MAIN = 1;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         age;
    } ent_t;

    typedef struct {
        int         cyc;
        logic [9:0] r;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready_o  [NCFG];
    logic [7:0] sum_o       [NCFG];
    logic       carry_o     [NCFG];
    logic       ovf_o       [NCFG];
    logic       out_valid_o [NCFG];

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic chkOn  = 1'b0;
    logic recOn  = 1'b0;
    rec_t rec[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference result from plain integer arithmetic: {carry, ovf, sum}.
    function automatic logic [9:0] refOp(logic [7:0] x, logic [7:0] y, logic ci, logic sb);
        int   ua, ub, sa, sy, us, ss;
        logic cy, ov;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            us = ua - ub;
            cy = (ua >= ub);
            ss = sa - sy;
        end else begin
            us = ua + ub + int'(ci);
            cy = (us > 255);
            ss = sa + sy + int'(ci);
        end
        ov = (ss > 127) || (ss < -128);
        return {cy, ov, us[7:0]};
    endfunction

    task automatic checkOutput(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got=%0h expected=%0h", name, cycle, got, exp);
        end
    endtask

    for (genvar i = 0; i < NCFG; i++) begin : g_cfg
        localparam int ST = 1 << i;

        ent_t q[$];

        pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .in_valid  (in_valid),
            .in_ready  (in_ready_o[i]),
            .sum       (sum_o[i]),
            .carry     (carry_o[i]),
            .ovf       (ovf_o[i]),
            .out_valid (out_valid_o[i]),
            .out_ready (out_ready)
        );

        // Each accepted op ages one step per enabled edge and is presented at age ST.
        always @(posedge clk) begin : model
            logic       mv, men;
            logic [9:0] r;
            mv  = (q.size() > 0) && (q[0].age == ST);
            men = !mv || out_ready;
            if (rst) begin
                q.delete();
            end else if (men) begin
                if (mv) void'(q.pop_front());
                foreach (q[j]) q[j].age = q[j].age + 1;
                if (in_valid) begin
                    r = refOp(a, b, cin, sub);
                    q.push_back('{r[7:0], r[9], r[8], 1});
                end
            end
        end

        always @(negedge clk) begin : compare
            logic        mv;
            logic [11:0] got, exp;
            if (chkOn) begin
                mv  = (q.size() > 0) && (q[0].age == ST);
                got = {in_ready_o[i], out_valid_o[i], 10'h0};
                exp = {!mv || out_ready, mv, 10'h0};
                if (out_valid_o[i]) got[9:0] = {sum_o[i], carry_o[i], ovf_o[i]};
                if (mv) exp[9:0] = {q[0].s, q[0].c, q[0].o};
                checkOutput($sformatf("model_st%0d", ST), int'(got), int'(exp));
            end
        end
    end

    always @(negedge clk) begin
        if (recOn && out_valid_o[MAIN] && out_ready)
            rec.push_back('{cycle, {carry_o[MAIN], ovf_o[MAIN], sum_o[MAIN]}});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [7:0] x, logic [7:0] y, logic ci, logic sb);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
    endtask

    task automatic runOne(string name, logic [7:0] x, logic [7:0] y, logic ci, logic sb,
                          logic [7:0] es, logic ec, logic eo);
        int lat;
        step();
        applyStimulus(x, y, ci, sb);
        @(negedge clk);
        checkOutput({name, "_rdy"}, int'(in_ready_o[MAIN]), 1);
        step();
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid_o[MAIN] && lat < 10) begin
            step();
            lat++;
            @(negedge clk);
        end
        checkOutput({name, "_lat"}, lat, 2);
        checkOutput({name, "_res"},
                    int'({out_valid_o[MAIN], sum_o[MAIN], carry_o[MAIN], ovf_o[MAIN]}),
                    int'({1'b1, es, ec, eo}));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] opA [4];
        logic [7:0] opB [4];
        logic [9:0] expR [4];
        logic       acc;
        int         tries, w;

        opA  = '{8'h01, 8'h10, 8'hFF, 8'h40};
        opB  = '{8'h02, 8'h20, 8'hFF, 8'h40};
        expR = '{10'h003, 10'h030, 10'h2FE, 10'h180};

        checkOutput("pin_ref_add", int'(refOp(8'h3C, 8'h0F, 1'b0, 1'b0)), 'h04B);
        checkOutput("pin_ref_sub", int'(refOp(8'h80, 8'h01, 1'b1, 1'b1)), 'h37F);

        repeat (2) step();
        chkOn = 1'b1;
        @(negedge clk);
        checkOutput("reset_state",
                    int'({in_ready_o[MAIN], out_valid_o[MAIN], sum_o[MAIN], carry_o[MAIN], ovf_o[MAIN]}),
                    int'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
        step();
        rst = 1'b0;

        runOne("add",    8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        runOne("ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        runOne("wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        runOne("sub",    8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        runOne("subovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Back-pressure: four ops streamed, output held for three cycles once valid.
        step();
        out_ready = 1'b0;
        recOn     = 1'b1;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    applyStimulus(opA[n], opB[n], 1'b0, 1'b0);
                    tries = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready_o[MAIN];
                        step();
                        tries++;
                    end while (!acc && tries < 20);
                    if (!acc) checkOutput("bp_accept", 0, 1);
                end
                in_valid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid_o[MAIN] && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int s = 0; s < 3; s++) begin
                    if (s > 0) @(negedge clk);
                    checkOutput("bp_hold",
                                int'({in_ready_o[MAIN], out_valid_o[MAIN], carry_o[MAIN], ovf_o[MAIN], sum_o[MAIN]}),
                                int'({1'b0, 1'b1, expR[0]}));
                end
                step();
                out_ready = 1'b1;
            end
        join
        repeat (6) step();
        recOn = 1'b0;
        checkOutput("bp_count", rec.size(), 4);
        for (int n = 0; n < 4 && n < rec.size(); n++) begin
            checkOutput($sformatf("bp_res%0d", n), int'(rec[n].r), int'(expR[n]));
            if (n > 0) checkOutput($sformatf("bp_gap%0d", n), rec[n].cyc - rec[n-1].cyc, 1);
        end

        // Reset lands while two ops are in flight; neither may surface.
        step();
        applyStimulus(8'h11, 8'h22, 1'b0, 1'b0);
        step();
        applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_flush", int'({out_valid_o[MAIN], sum_o[MAIN]}), 0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            @(negedge clk);
            checkOutput("rst_quiet", int'(out_valid_o[MAIN]), 0);
        end

        // Random sweep across all four pipeline depths with random back-pressure.
        step();
        for (int n = 0; n < 1000; n++) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
